piece_queue: RTL

- Sits directly downstream of the 7-bag randomiser (`bag`).
- Requests a fresh bag, waits for `done`, then copies the 7 pieces one per cycle into a circular FIFO.
- Serves pieces to the game controller on `pop` and exposes a next-piece preview window.
- Keeps the queue topped up so the game never starves while a new bag is generated.

---
 rtl/piece_queue_if.sv | 38 +++
 rtl/piece_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/piece_queue_if.sv
// piece_queue_if: bag-side and game-side signals of piece_queue; PIECE_QUEUE_HOLD_EN adds the hold slot ports
interface piece_queue_if #(
    parameter int PIECE_W = 3,
    parameter int PREVIEW = 3
);
    logic                            bag_done;
    logic [PIECE_W-1:0]              bag_in [6:0];
    logic                            newbag;
    logic                            pop;
    logic [PIECE_W-1:0]              piece;
    logic                            piece_valid;
    logic [PREVIEW-1:0][PIECE_W-1:0] preview;
    logic [PREVIEW-1:0]              preview_valid;
    logic [4:0]                      count;
    logic                            loading;
`ifdef PIECE_QUEUE_HOLD_EN
    logic                            hold;
    logic [PIECE_W-1:0]              held_piece;
    logic                            held_valid;
    modport master (
        output bag_done, bag_in, pop, hold,
        input  newbag, piece, piece_valid, preview, preview_valid, count, loading, held_piece, held_valid
    );
    modport slave (
        input  bag_done, bag_in, pop, hold,
        output newbag, piece, piece_valid, preview, preview_valid, count, loading, held_piece, held_valid
    );
`else
    modport master (
        output bag_done, bag_in, pop,
        input  newbag, piece, piece_valid, preview, preview_valid, count, loading
    );
    modport slave (
        input  bag_done, bag_in, pop,
        output newbag, piece, piece_valid, preview, preview_valid, count, loading
    );
`endif
endinterface

// File: rtl/piece_queue.sv
// piece_queue: circular piece FIFO fed from the 7-bag randomiser with head/preview reads; PIECE_QUEUE_HOLD_EN adds a hold slot
module piece_queue #(
    parameter int QUEUE_DEPTH = 14,
    parameter int PREVIEW     = 3,
    parameter int PIECE_W     = 3
) (
    input logic          clk,
    input logic          reset,
    piece_queue_if.slave bus
);
    typedef enum logic [1:0] {REQ, WAIT, LOAD, CHECK} state_t;
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0]   DEPTH = (AW+1)'(QUEUE_DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(QUEUE_DEPTH - 1);

    state_t             state, state_next;
    logic [PIECE_W-1:0] mem [QUEUE_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [4:0]         count;
    logic [2:0]         k;
    logic               seen_low;
    logic               push, do_pop, piece_valid;
    logic               hold_pop, swap;
    logic [PIECE_W-1:0] head, held_piece;
    logic [4:0]         free;
    logic [PREVIEW-1:0]              pv_valid;
    logic [PREVIEW-1:0][PIECE_W-1:0] pv;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head        = mem[rd_ptr];
    assign piece_valid = count != 5'd0;
    assign free        = 5'(QUEUE_DEPTH) - count;
    assign push        = state == LOAD;
    assign do_pop      = (bus.pop && piece_valid) || hold_pop;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= REQ;
        else       state <= state_next;
    end

    // FSM next state and bag-side outputs; newbag stays low while reset is held
    always_comb begin
        state_next  = state;
        bus.newbag  = 1'b0;
        bus.loading = 1'b0;
        case (state)
            REQ: begin
                bus.newbag = !reset;
                state_next = WAIT;
            end
            WAIT:    state_next = (seen_low && bus.bag_done) ? LOAD : WAIT;
            LOAD: begin
                bus.loading = 1'b1;
                state_next  = (k == 3'd6) ? CHECK : LOAD;
            end
            CHECK:   state_next = (free >= 5'd7) ? REQ : CHECK;
            default: state_next = REQ;
        endcase
    end

    // pointers, occupancy, deal index and the stale-done guard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            k        <= '0;
            seen_low <= 1'b0;
        end else begin
            if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
            if (push)   wr_ptr <= wrap_inc(wr_ptr);
            count    <= count + {4'b0, push} - {4'b0, do_pop};
            k        <= (state == LOAD && k != 3'd6) ? k + 3'd1 : 3'd0;
            seen_low <= (state == REQ) ? 1'b0 : (state == WAIT) ? (seen_low | ~bus.bag_done) : seen_low;
        end
    end

    // piece storage: bag deal at the tail, hold swap at the head (never the same slot while loading)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.bag_in[k];
        if (swap) mem[rd_ptr] <= held_piece;
    end

`ifdef PIECE_QUEUE_HOLD_EN
    logic held_valid, hold_lock, hold_act;
    assign hold_act = bus.hold && !hold_lock && piece_valid && !bus.pop;
    assign hold_pop = hold_act && !held_valid;
    assign swap     = hold_act && held_valid;

    // hold slot: first hold parks the head, later holds swap; a pop re-arms
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_piece <= '0;
            held_valid <= 1'b0;
            hold_lock  <= 1'b0;
        end else if (hold_act) begin
            held_piece <= head;
            held_valid <= 1'b1;
            hold_lock  <= 1'b1;
        end else if (bus.pop) begin
            hold_lock  <= 1'b0;
        end
    end

    assign bus.held_piece = held_piece;
    assign bus.held_valid = held_valid;
`else
    assign hold_pop   = 1'b0;
    assign swap       = 1'b0;
    assign held_piece = '0;
`endif

    for (genvar g = 0; g < PREVIEW; g++) begin : g_prev
        logic [AW:0]   s;
        logic [AW-1:0] idx;
        assign s           = {1'b0, rd_ptr} + (AW+1)'(g + 1);
        assign idx         = AW'((s >= DEPTH) ? s - DEPTH : s);
        assign pv_valid[g] = count > 5'(g + 1);
        assign pv[g]       = pv_valid[g] ? mem[idx] : '0;
    end

    assign bus.piece         = piece_valid ? head : '0;
    assign bus.piece_valid   = piece_valid;
    assign bus.preview       = pv;
    assign bus.preview_valid = pv_valid;
    assign bus.count         = count;
endmodule
